// File: rtl/tft_spi_pkg.sv
// tft_spi_pkg: FSM encoding and default timing constants shared by the TFT SPI transmitter.
package tft_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEFAULT_CLK_DIV    = 4;
  localparam int DEFAULT_GAP_CYCLES = 2;
  localparam int FRAME_BITS         = 16;

endpackage

// File: rtl/tft_spi_clkdiv.sv
// tft_spi_clkdiv: counts MasterCLK cycles while enabled and pulses tick for one
// cycle at terminal count DIV-1, restarting from zero on the following cycle.
module tft_spi_clkdiv import tft_spi_pkg::*; #(
  parameter int DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] TERM = 8'(DIV - 1);

  logic [7:0] count;

  // Divider counter: held at zero while disabled so every SHIFT entry starts a fresh half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (!enable || count == TERM) begin
      count <= 8'd0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign tick = enable && (count == TERM);

endmodule

// File: rtl/tft_spi.sv
// tft_spi: free-running 16-bit SPI mode-0 transmitter for a TFT panel. Each frame
// loads data in IDLE, shifts it out MSB first in SHIFT, then rests in GAP.
module tft_spi import tft_spi_pkg::*; #(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic        MasterCLK,
  input  logic        MasterRST_n,
  input  logic [15:0] data,
  output logic        SPI_MOSI,
  output logic        SPI_CLK,
  output logic [16:0] OutputData
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] shreg;
  logic [15:0] word;
  logic [15:0] last_word;
  logic [3:0]  bit_cnt;
  logic [7:0]  gap_cnt;
  logic        busy;
  logic        tick;
  logic        div_en;
  logic        load;
  logic        rise;
  logic        shift;
  logic        finish;
  logic        gap_step;

  assign div_en = (state == ST_SHIFT);

  tft_spi_clkdiv #(.DIV(CLK_DIV)) u_clkdiv (
    .clk    (MasterCLK),
    .rst_n  (MasterRST_n),
    .enable (div_en),
    .tick   (tick)
  );

  // State register; reset parks the FSM in IDLE so the first edge after release loads a word.
  always_ff @(posedge MasterCLK or negedge MasterRST_n) begin
    if (!MasterRST_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-cycle datapath strobes; GAP exits on the cycle its counter reaches GAP_CYCLES.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    rise       = 1'b0;
    shift      = 1'b0;
    finish     = 1'b0;
    gap_step   = 1'b0;
    case (state)
      ST_IDLE: begin
        load       = 1'b1;
        next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!SPI_CLK) begin
            rise = 1'b1;
          end else if (bit_cnt == LAST_BIT) begin
            finish     = 1'b1;
            next_state = ST_GAP;
          end else begin
            shift = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = ST_IDLE;
        end else begin
          gap_step = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered datapath: every output bit comes from a flop, and OutputData only changes on a full frame.
  always_ff @(posedge MasterCLK or negedge MasterRST_n) begin
    if (!MasterRST_n) begin
      shreg     <= 16'd0;
      word      <= 16'd0;
      last_word <= 16'd0;
      bit_cnt   <= 4'd0;
      gap_cnt   <= 8'd0;
      busy      <= 1'b0;
      SPI_CLK   <= 1'b0;
      SPI_MOSI  <= 1'b0;
    end else if (load) begin
      shreg    <= data;
      word     <= data;
      SPI_MOSI <= data[15];
      bit_cnt  <= 4'd0;
      gap_cnt  <= 8'd0;
      busy     <= 1'b1;
      SPI_CLK  <= 1'b0;
    end else if (finish) begin
      SPI_CLK   <= 1'b0;
      SPI_MOSI  <= 1'b0;
      last_word <= word;
      busy      <= 1'b0;
      gap_cnt   <= 8'd0;
    end else if (shift) begin
      SPI_CLK  <= 1'b0;
      shreg    <= shreg << 1;
      SPI_MOSI <= shreg[14];
      bit_cnt  <= bit_cnt + 4'd1;
    end else if (rise) begin
      SPI_CLK <= 1'b1;
    end else if (gap_step) begin
      gap_cnt <= gap_cnt + 8'd1;
    end
  end

  assign OutputData = {busy, last_word};

endmodule

// File: tb/tb_tft_spi.sv
// tb_tft_spi: scoreboard bench for tft_spi at default timing (dut_a) and at
// CLK_DIV=1 / GAP_CYCLES=0 (dut_b). Monitors rebuild each frame from the SPI pins.
module tb_tft_spi;

  typedef struct {
    logic [15:0] word;
    int          hi_min;
    int          hi_max;
    int          lo_min;
    int          lo_max;
    int          lead_lo;
    int          unstable;
  } frame_t;

  logic        clk;
  logic        rst_a_n;
  logic        rst_b_n;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic        mosi_a;
  logic        sclk_a;
  logic [16:0] out_a;
  logic        mosi_b;
  logic        sclk_b;
  logic [16:0] out_b;

  frame_t      fr_a[$];
  frame_t      fr_b[$];
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  int checks = 0;
  int errors = 0;

  tft_spi dut_a (
    .MasterCLK   (clk),
    .MasterRST_n (rst_a_n),
    .data        (data_a),
    .SPI_MOSI    (mosi_a),
    .SPI_CLK     (sclk_a),
    .OutputData  (out_a)
  );

  tft_spi #(.CLK_DIV(1), .GAP_CYCLES(0)) dut_b (
    .MasterCLK   (clk),
    .MasterRST_n (rst_b_n),
    .data        (data_b),
    .SPI_MOSI    (mosi_b),
    .SPI_CLK     (sclk_b),
    .OutputData  (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rebuild frames from the pins: word sampled at SPI_CLK rises, phase lengths in MasterCLK cycles.
  task automatic run_monitor(input int which);
    frame_t cur;
    int     run;
    int     rises;
    logic   prev_clk;
    logic   prev_mosi;
    logic   c;
    logic   m;
    logic   r;
    run = 0; rises = 0; prev_clk = 1'b0; prev_mosi = 1'b0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      c = (which == 0) ? sclk_a : sclk_b;
      m = (which == 0) ? mosi_a : mosi_b;
      r = (which == 0) ? rst_a_n : rst_b_n;
      if (r !== 1'b1) begin
        run = 0; rises = 0; prev_clk = 1'b0; prev_mosi = 1'b0;
        cur = '{default: 0};
      end else begin
        if (c !== prev_clk) begin
          if (c === 1'b1) begin
            if (rises == 0) begin
              cur = '{default: 0};
              cur.lead_lo = run;
              cur.hi_min = 1000; cur.lo_min = 1000;
            end else begin
              if (run < cur.lo_min) cur.lo_min = run;
              if (run > cur.lo_max) cur.lo_max = run;
            end
            if (m !== prev_mosi) cur.unstable++;
            cur.word = {cur.word[14:0], m};
            rises++;
          end else begin
            if (run < cur.hi_min) cur.hi_min = run;
            if (run > cur.hi_max) cur.hi_max = run;
            if (rises == 16) begin
              if (which == 0) fr_a.push_back(cur);
              else fr_b.push_back(cur);
              rises = 0;
            end
          end
          run = 1;
        end else begin
          run++;
        end
        prev_clk = c;
        prev_mosi = m;
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  // Bounded wait for the monitor to collect n frames.
  task automatic wait_frames(input int which, input int n, input int budget, output bit ok);
    int k;
    k = 0;
    ok = 1'b0;
    while (k < budget) begin
      if (((which == 0) ? fr_a.size() : fr_b.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    data_a = 16'hFFFF; data_b = 16'h5A3C;
    repeat (5) @(negedge clk);
    checks++;
    if (sclk_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk got %b want 0", sclk_a); end
    checks++;
    if (mosi_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi got %b want 0", mosi_a); end
    checks++;
    if (out_a !== 17'h0) begin errors++; $display("[TB] FAIL reset_out got %h want 00000", out_a); end
    checks++;
    if ({out_b, sclk_b, mosi_b} !== 19'h0) begin
      errors++; $display("[TB] FAIL reset_b got out=%h sclk=%b mosi=%b want zeros", out_b, sclk_b, mosi_b);
    end
  endtask

  task automatic test_all_ones();
    frame_t f;
    bit     ok;
    logic [15:0] e;
    exp_a.push_back(16'hFFFF); exp_a.push_back(16'hFFFF);
    #1 rst_a_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_a !== 17'h10000) begin errors++; $display("[TB] FAIL ones_first_idle got %h want 10000", out_a); end
    repeat (127) @(negedge clk);
    checks++;
    if (out_a !== 17'h10000) begin errors++; $display("[TB] FAIL ones_before_end got %h want 10000", out_a); end
    @(negedge clk);
    checks++;
    if ({out_a, sclk_a, mosi_a} !== {17'h0FFFF, 2'b00}) begin
      errors++; $display("[TB] FAIL ones_frame_end got out=%h sclk=%b mosi=%b want 0ffff/0/0", out_a, sclk_a, mosi_a);
    end
    wait_frames(0, 2, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL ones_timeout got %0d frames want 2", fr_a.size()); end
    if (ok) begin
      for (int i = 0; i < 2; i++) begin
        f = fr_a.pop_front();
        e = exp_a.pop_front();
        checks++;
        if (f.word !== e) begin errors++; $display("[TB] FAIL ones_word%0d got %h want %h", i, f.word, e); end
        checks++;
        if (f.hi_min !== 4 || f.hi_max !== 4 || f.lo_min !== 4 || f.lo_max !== 4 ||
            f.lead_lo !== ((i == 0) ? 4 : 8) || f.unstable !== 0) begin
          errors++;
          $display("[TB] FAIL ones_timing%0d got hi=%0d..%0d lo=%0d..%0d lead=%0d unstable=%0d want hi=4 lo=4 lead=%0d unstable=0",
                   i, f.hi_min, f.hi_max, f.lo_min, f.lo_max, f.lead_lo, f.unstable, (i == 0) ? 4 : 8);
        end
      end
    end
  endtask

  task automatic test_a55a();
    frame_t f;
    bit     ok;
    int     busy_bad;
    logic   exp_busy;
    logic [15:0] e;
    @(negedge clk);
    #1 rst_a_n = 1'b0; data_a = 16'hA55A;
    repeat (3) @(negedge clk);
    fr_a.delete(); exp_a.delete();
    exp_a.push_back(16'hA55A); exp_a.push_back(16'hA55A);
    #1 rst_a_n = 1'b1;
    busy_bad = 0;
    for (int k = 1; k <= 264; k++) begin
      @(negedge clk);
      exp_busy = (((k - 1) % 132) < 128);
      if (out_a[16] !== exp_busy) busy_bad++;
    end
    checks++;
    if (busy_bad != 0) begin errors++; $display("[TB] FAIL a55a_busy_window got %0d bad cycles want 0", busy_bad); end
    checks++;
    if (out_a[15:0] !== 16'hA55A) begin errors++; $display("[TB] FAIL a55a_out got %h want a55a", out_a[15:0]); end
    wait_frames(0, 2, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL a55a_timeout got %0d frames want 2", fr_a.size()); end
    if (ok) begin
      for (int i = 0; i < 2; i++) begin
        f = fr_a.pop_front();
        e = exp_a.pop_front();
        checks++;
        if (f.word !== e || f.unstable !== 0) begin
          errors++; $display("[TB] FAIL a55a_word%0d got %b unstable=%0d want %b", i, f.word, f.unstable, e);
        end
      end
    end
  endtask

  task automatic test_data_change();
    frame_t f;
    bit     ok;
    logic [15:0] e;
    @(negedge clk);
    #1 rst_a_n = 1'b0; data_a = 16'h1234;
    repeat (3) @(negedge clk);
    fr_a.delete(); exp_a.delete();
    exp_a.push_back(16'h1234);
    #1 rst_a_n = 1'b1;
    repeat (37) @(negedge clk);
    checks++;
    if (sclk_a !== 1'b1) begin errors++; $display("[TB] FAIL change_rise5_sclk got %b want 1", sclk_a); end
    #1 data_a = 16'hFFFF;
    exp_a.push_back(16'hFFFF);
    wait_frames(0, 2, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL change_timeout got %0d frames want 2", fr_a.size()); end
    if (ok) begin
      for (int i = 0; i < 2; i++) begin
        f = fr_a.pop_front();
        e = exp_a.pop_front();
        checks++;
        if (f.word !== e) begin errors++; $display("[TB] FAIL change_word%0d got %h want %h", i, f.word, e); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    bit     ok;
    logic [15:0] e;
    @(negedge clk);
    #1 rst_a_n = 1'b0; data_a = 16'hC3A5;
    repeat (3) @(negedge clk);
    fr_a.delete(); exp_a.delete();
    exp_a.push_back(16'hC3A5);
    #1 rst_a_n = 1'b1;
    repeat (193) @(negedge clk);
    checks++;
    if ({out_a, sclk_a, mosi_a} !== {17'h1C3A5, 2'b11}) begin
      errors++; $display("[TB] FAIL mid_before got out=%h sclk=%b mosi=%b want 1c3a5/1/1", out_a, sclk_a, mosi_a);
    end
    wait_frames(0, 1, 1, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL mid_first_frame got %0d frames want 1", fr_a.size()); end
    if (ok) begin
      f = fr_a.pop_front();
      e = exp_a.pop_front();
      checks++;
      if (f.word !== e) begin errors++; $display("[TB] FAIL mid_word0 got %h want %h", f.word, e); end
    end
    #2 rst_a_n = 1'b0;
    #1;
    checks++;
    if ({out_a, sclk_a, mosi_a} !== 19'h0) begin
      errors++; $display("[TB] FAIL mid_async_reset got out=%h sclk=%b mosi=%b want zeros", out_a, sclk_a, mosi_a);
    end
    repeat (3) @(negedge clk);
    fr_a.delete(); exp_a.delete();
    exp_a.push_back(16'hC3A5);
    #1 rst_a_n = 1'b1;
    repeat (129) @(negedge clk);
    checks++;
    if (out_a !== 17'h0C3A5) begin errors++; $display("[TB] FAIL mid_after_release got %h want 0c3a5", out_a); end
    wait_frames(0, 1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL mid_release_timeout got %0d frames want 1", fr_a.size()); end
    if (ok) begin
      f = fr_a.pop_front();
      e = exp_a.pop_front();
      checks++;
      if (f.word !== e) begin errors++; $display("[TB] FAIL mid_word1 got %h want %h", f.word, e); end
    end
  endtask

  task automatic test_fast();
    frame_t f;
    bit     ok;
    logic   prev_busy;
    int     rise_at[$];
    logic [15:0] e;
    repeat (3) exp_b.push_back(16'h5A3C);
    #1 rst_b_n = 1'b1;
    prev_busy = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (out_b[16] === 1'b1 && prev_busy === 1'b0) rise_at.push_back(k);
      prev_busy = out_b[16];
    end
    checks++;
    if (rise_at.size() < 3) begin
      errors++; $display("[TB] FAIL fast_idle_count got %0d frame starts want 3", rise_at.size());
    end else begin
      checks++;
      if (rise_at[0] != 1) begin errors++; $display("[TB] FAIL fast_first_idle got cycle %0d want 1", rise_at[0]); end
      checks++;
      if (rise_at[1] - rise_at[0] != 34 || rise_at[2] - rise_at[1] != 34) begin
        errors++; $display("[TB] FAIL fast_period got %0d,%0d want 34,34", rise_at[1] - rise_at[0], rise_at[2] - rise_at[1]);
      end
    end
    wait_frames(1, 3, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL fast_timeout got %0d frames want 3", fr_b.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        f = fr_b.pop_front();
        e = exp_b.pop_front();
        checks++;
        if (f.word !== e || f.hi_min !== 1 || f.hi_max !== 1 || f.lo_min !== 1 || f.lo_max !== 1 ||
            f.lead_lo !== ((i == 0) ? 1 : 3)) begin
          errors++;
          $display("[TB] FAIL fast_frame%0d got word=%h hi=%0d..%0d lo=%0d..%0d lead=%0d want %h hi=1 lo=1 lead=%0d",
                   i, f.word, f.hi_min, f.hi_max, f.lo_min, f.lo_max, f.lead_lo, e, (i == 0) ? 1 : 3);
        end
      end
    end
  endtask

  task automatic test_continuous();
    frame_t f;
    logic   prev_busy;
    int     started;
    int     done;
    int     budget;
    int     exp_lead;
    logic [15:0] e;
    @(negedge clk);
    #1 rst_b_n = 1'b0;
    repeat (2) @(negedge clk);
    fr_b.delete(); exp_b.delete();
    data_b = 16'($urandom);
    exp_b.push_back(data_b);
    #1 rst_b_n = 1'b1;
    prev_busy = 1'b0; started = 0; done = 0; budget = 0;
    while (done < 1000 && budget < 34200) begin
      @(negedge clk);
      budget++;
      if (out_b[16] === 1'b1 && prev_busy === 1'b0) begin
        started++;
        if (started < 1000) begin
          #1 data_b = 16'($urandom);
          exp_b.push_back(data_b);
        end
      end
      prev_busy = out_b[16];
      while (fr_b.size() > 0 && done < 1000) begin
        f = fr_b.pop_front();
        e = (exp_b.size() > 0) ? exp_b.pop_front() : 16'hxxxx;
        exp_lead = (done == 0) ? 1 : 3;
        checks++;
        if (f.word !== e) begin errors++; $display("[TB] FAIL cont_word%0d got %h want %h", done, f.word, e); end
        checks++;
        if (f.hi_min !== 1 || f.hi_max !== 1 || f.lo_min !== 1 || f.lo_max !== 1 ||
            f.lead_lo !== exp_lead || f.unstable !== 0) begin
          errors++;
          $display("[TB] FAIL cont_timing%0d got hi=%0d..%0d lo=%0d..%0d lead=%0d unstable=%0d want 1/1/%0d/0",
                   done, f.hi_min, f.hi_max, f.lo_min, f.lo_max, f.lead_lo, f.unstable, exp_lead);
        end
        done++;
      end
    end
    checks++;
    if (done != 1000) begin errors++; $display("[TB] FAIL cont_frame_count got %0d want 1000", done); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_a55a();
    test_data_change();
    test_reset_midframe();
    test_fast();
    test_continuous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
